// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/run-control bus between the ID-stage datapath and the sequencer.
// master drives the decoded ID fields and debug requests; slave (the sequencer)
// returns latch controls, stall statistics and run state.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             exMemRead;
   logic [4:0]       exRegRt;
   logic [4:0]       idRegRs;
   logic [4:0]       idRegRt;
   logic             idUsesRt;
   logic             branchTaken;
   logic             haltInstr;
   logic             stepReq;
   logic             runReq;
   logic             pcEnable;
   logic             ifIdEnable;
   logic             idExEnable;
   logic             ifIdFlush;
   logic             idExBubble;
   logic [CNT_W-1:0] stallCount;
   logic [1:0]       state;
   logic             halted;

   modport master (
      output exMemRead, exRegRt, idRegRs, idRegRt, idUsesRt,
             branchTaken, haltInstr, stepReq, runReq,
      input  pcEnable, ifIdEnable, idExEnable, ifIdFlush, idExBubble,
             stallCount, state, halted
   );

   modport slave (
      input  exMemRead, exRegRt, idRegRs, idRegRt, idUsesRt,
             branchTaken, haltInstr, stepReq, runReq,
      output pcEnable, ifIdEnable, idExEnable, ifIdFlush, idExBubble,
             stallCount, state, halted
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and run-control sequencer for the five-stage pipeline.
// Resolves load-use stalls and taken-branch flushes in the same cycle they are
// seen, and runs a debug halt / single-step / resume controller. Latch controls
// are combinational from the registered run state plus the current ID fields.
module pipeline_hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_HALT  = 2'd2,
      S_STEP  = 2'd3
   } state_t;

   state_t           st_q, st_d;
   logic [2:0]       drain_q, drain_d;
   logic             skip_q, skip_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_inc;
   logic             lu;
   logic             pc_en, ifid_en, idex_en, ifid_fl, idex_bub;

   // Load in EX writes a register the ID instruction reads; $0 never hazards.
   assign lu = bus.exMemRead && (bus.exRegRt != 5'd0) &&
               ((bus.exRegRt == bus.idRegRs) ||
                (bus.idUsesRt && (bus.exRegRt == bus.idRegRt)));

   // Saturating stall counter: stays at all-ones once reached.
   assign cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

   // Run-state, drain counter, resume-skip flag and stall statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_q    <= S_RUN;
         drain_q <= 3'd0;
         skip_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         st_q    <= st_d;
         drain_q <= drain_d;
         skip_q  <= skip_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and latch controls. Default is a free-flowing pipeline.
   always_comb begin
      st_d     = st_q;
      drain_d  = drain_q;
      skip_d   = skip_q;
      cnt_inc  = 1'b0;
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      ifid_fl  = 1'b0;
      idex_bub = 1'b0;
      if (reset) begin
         // Clear both latches while reset is held; PC stays put.
         pc_en    = 1'b0;
         ifid_fl  = 1'b1;
         idex_bub = 1'b1;
      end else begin
         unique case (st_q)
            S_RUN, S_STEP: begin
               // skipHalt only shields the first RUN cycle after resume.
               if (st_q == S_RUN) skip_d = 1'b0;
               // A step is exactly one cycle of RUN rules, whatever they did.
               if (st_q == S_STEP) st_d = S_HALT;
               if (bus.branchTaken) begin
                  ifid_fl  = 1'b1;
                  idex_bub = 1'b1;
               end else if ((st_q == S_RUN) && bus.haltInstr && !skip_q) begin
                  // Freeze the front end behind the halt and start draining.
                  pc_en    = 1'b0;
                  ifid_en  = 1'b0;
                  idex_bub = 1'b1;
                  st_d     = S_DRAIN;
                  drain_d  = 3'(DRAIN_CYCLES - 1);
               end else if (lu) begin
                  pc_en    = 1'b0;
                  ifid_en  = 1'b0;
                  idex_bub = 1'b1;
                  cnt_inc  = 1'b1;
               end
            end
            S_DRAIN: begin
               if (bus.branchTaken) begin
                  // The halt was fetched down the wrong path; drop it.
                  ifid_fl  = 1'b1;
                  idex_bub = 1'b1;
                  st_d     = S_RUN;
               end else begin
                  pc_en    = 1'b0;
                  ifid_en  = 1'b0;
                  idex_bub = 1'b1;
                  if (drain_q == 3'd0) st_d = S_HALT;
                  else                 drain_d = drain_q - 3'd1;
               end
            end
            S_HALT: begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               idex_en = 1'b0;
               if (bus.runReq) begin
                  st_d   = S_RUN;
                  skip_d = 1'b1;
               end else if (bus.stepReq) begin
                  st_d = S_STEP;
               end
            end
            default: st_d = S_RUN;
         endcase
      end
   end

   assign bus.pcEnable   = pc_en;
   assign bus.ifIdEnable = ifid_en;
   assign bus.idExEnable = idex_en;
   assign bus.ifIdFlush  = ifid_fl;
   assign bus.idExBubble = idex_bub;
   assign bus.stallCount = cnt_q;
   assign bus.state      = st_q;
   assign bus.halted     = (st_q == S_HALT);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed stimulus, literal spot checks and
// a cycle-by-cycle behavioural model of the run-control rules.
module tb_pipeline_hazard_ctrl;
   localparam int D     = 3;
   localparam int CNT_W = 16;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

   pipeline_hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Actions as {pcEnable, ifIdEnable, ifIdFlush, idExEnable, idExBubble}.
   localparam logic [4:0] A_ADV   = 5'b11010;
   localparam logic [4:0] A_FLUSH = 5'b11111;
   localparam logic [4:0] A_STALL = 5'b00011;
   localparam logic [4:0] A_HOLD  = 5'b00000;
   localparam logic [4:0] A_RST   = 5'b01111;

   int         mmode  = 0;   // 0 run, 1 drain, 2 halted, 3 single step
   int         mcyc   = 0;
   int         mdrain_end = 0;
   bit         mskip  = 0;
   int         mcnt   = 0;
   bit         mvalid = 0;

   always @(negedge clk) begin
      logic [4:0] act;
      logic [4:0] got;
      bit         luh;
      int         nmode;
      mcyc++;
      luh = hif.exMemRead && (hif.exRegRt != 0) &&
            ((hif.exRegRt == hif.idRegRs) || (hif.idUsesRt && (hif.exRegRt == hif.idRegRt)));
      nmode = mmode;
      act   = A_ADV;
      if (reset) begin
         act = A_RST;
      end else if (mmode == 0 || mmode == 3) begin
         if (hif.branchTaken) act = A_FLUSH;
         else if (mmode == 0 && hif.haltInstr && !mskip) begin
            act = A_STALL;
            nmode = 1;
            mdrain_end = mcyc + D;
         end else if (luh) act = A_STALL;
         else act = A_ADV;
         if (mmode == 3) nmode = 2;
      end else if (mmode == 1) begin
         if (hif.branchTaken) begin
            act = A_FLUSH;
            nmode = 0;
         end else begin
            act = A_STALL;
            if (mcyc == mdrain_end) nmode = 2;
         end
      end else begin
         act = A_HOLD;
         if (hif.runReq) nmode = 0;
         else if (hif.stepReq) nmode = 3;
      end

      got = {hif.pcEnable, hif.ifIdEnable, hif.ifIdFlush, hif.idExEnable, hif.idExBubble};
      chk("model_ctl", int'(got), int'(act));
      if (mvalid && !reset) begin
         chk("model_state", int'(hif.state), mmode);
         chk("model_halted", int'(hif.halted), int'(mmode == 2));
         chk("model_cnt", int'(hif.stallCount), mcnt);
      end

      if (reset) begin
         mmode = 0; mskip = 0; mcnt = 0; mvalid = 1;
      end else begin
         if ((mmode == 0 || mmode == 3) && act == A_STALL && nmode != 1 && mcnt < SAT)
            mcnt++;
         if (mmode == 0) mskip = 0;
         if (mmode == 2 && hif.runReq) mskip = 1;
         mmode = nmode;
      end
   end

   // ---------------- stimulus ----------------
   task automatic setin(input bit mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input bit ut, input bit bt,
                        input bit hi, input bit sr, input bit rr);
      hif.exMemRead = mr;  hif.exRegRt = ert; hif.idRegRs = rs; hif.idRegRt = rt;
      hif.idUsesRt = ut;   hif.branchTaken = bt; hif.haltInstr = hi;
      hif.stepReq = sr;    hif.runReq = rr;
   endtask

   task automatic idle();
      setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #2;
      chk("rst_pc", int'(hif.pcEnable), 0);
      chk("rst_ifen", int'(hif.ifIdEnable), 1);
      chk("rst_flush", int'(hif.ifIdFlush), 1);
      chk("rst_bubble", int'(hif.idExBubble), 1);
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_state", int'(hif.state), 0);
      chk("rst_cnt", int'(hif.stallCount), 0);

      // lw $5 in EX, add in ID reads rs=$5
      setin(1, 5, 5, 0, 1, 0, 0, 0, 0); #1;
      chk("lu_pc", int'(hif.pcEnable), 0);
      chk("lu_ifen", int'(hif.ifIdEnable), 0);
      chk("lu_bubble", int'(hif.idExBubble), 1);
      chk("lu_cnt_before", int'(hif.stallCount), 0);
      tick();
      idle(); #1;
      chk("lu_cnt_after", int'(hif.stallCount), 1);
      chk("lu_release_pc", int'(hif.pcEnable), 1);
      tick();

      // hazard on rt only matters when the ID instruction reads rt
      setin(1, 7, 3, 7, 1, 0, 0, 0, 0); #1;
      chk("lurt_pc", int'(hif.pcEnable), 0);
      tick();
      setin(1, 7, 3, 7, 0, 0, 0, 0, 0); #1;
      chk("nort_pc", int'(hif.pcEnable), 1);
      tick();

      // loads into $0 never stall
      setin(1, 0, 0, 0, 1, 0, 0, 0, 0); #1;
      chk("r0_pc", int'(hif.pcEnable), 1);
      chk("r0_bubble", int'(hif.idExBubble), 0);
      tick();

      // branch flush beats load-use
      setin(1, 5, 5, 0, 0, 1, 0, 0, 0); #1;
      chk("prio_flush", int'(hif.ifIdFlush), 1);
      chk("prio_pc", int'(hif.pcEnable), 1);
      tick();
      idle(); #1;
      chk("prio_cnt", int'(hif.stallCount), 2);
      tick();

      // halt drain
      setin(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
      chk("halt_pc", int'(hif.pcEnable), 0);
      chk("halt_state", int'(hif.state), 0);
      tick();
      for (int i = 0; i < D; i++) begin
         chk("drain_state", int'(hif.state), 1);
         chk("drain_halted", int'(hif.halted), 0);
         tick();
      end
      chk("halted", int'(hif.halted), 1);
      chk("halt_enables", int'({hif.pcEnable, hif.ifIdEnable, hif.idExEnable}), 0);

      // single step with the halt still sitting in ID
      setin(0, 0, 0, 0, 0, 0, 1, 1, 0);
      tick();
      setin(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
      chk("step_state", int'(hif.state), 3);
      chk("step_enables", int'({hif.pcEnable, hif.ifIdEnable, hif.idExEnable}), 7);
      tick();
      chk("step_back", int'(hif.state), 2);

      // stepReq held: HALT, STEP, HALT, STEP, ...
      setin(0, 0, 0, 0, 0, 0, 1, 1, 0);
      tick(); chk("hold_step1", int'(hif.state), 3);
      tick(); chk("hold_halt1", int'(hif.state), 2);
      tick(); chk("hold_step2", int'(hif.state), 3);
      setin(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick(); chk("hold_halt2", int'(hif.state), 2);

      // resume: runReq wins over stepReq, halt ignored for one cycle
      setin(0, 0, 0, 0, 0, 0, 1, 1, 1);
      tick();
      setin(0, 0, 0, 0, 0, 0, 1, 0, 0); #1;
      chk("resume_state", int'(hif.state), 0);
      chk("resume_pc", int'(hif.pcEnable), 1);
      tick();
      idle();
      tick();

      // wrong-path halt squashed by a branch in the second drain cycle
      setin(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
      chk("wp_drain1", int'(hif.state), 1);
      tick();
      setin(0, 0, 0, 0, 0, 1, 1, 0, 0); #1;
      chk("wp_flush", int'(hif.ifIdFlush), 1);
      chk("wp_bubble", int'(hif.idExBubble), 1);
      tick();
      idle(); #1;
      chk("wp_state", int'(hif.state), 0);
      tick();

      // saturation: hold a load-use hazard long enough to wrap a 16-bit count
      setin(1, 9, 9, 0, 0, 0, 0, 0, 0);
      repeat (SAT + 5) tick();
      chk("sat_cnt", int'(hif.stallCount), SAT);
      idle();
      tick();

      // reset while halted, with a stale run request present
      setin(0, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (D + 1) tick();
      chk("pre_rst_halted", int'(hif.halted), 1);
      setin(0, 0, 0, 0, 0, 0, 1, 0, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle(); #1;
      chk("halt_rst_state", int'(hif.state), 0);
      chk("halt_rst_cnt", int'(hif.stallCount), 0);

      // debug requests outside HALT are ignored
      setin(0, 0, 0, 0, 0, 0, 0, 1, 1);
      tick();
      idle(); #1;
      chk("req_in_run", int'(hif.state), 0);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
